// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential multiply/divide unit with private HI/LO registers.
// One radix-2 step per cycle: shift-add for mult, restoring shift-subtract
// for div. Signed ops run on magnitudes, and the FIX state corrects the signs.
// Ports:
//   clk, reset (async, active low)
//   startE/opE/srcaE/srcbE : op request (00 mult, 01 multu, 10 div, 11 divu)
//   cancelE                : abort an op that is still iterating
//   hiweE/loweE/wdataE     : mthi/mtlo writes, honoured only while idle
//   hlreadD                : mfhi/mflo in decode (used only to build stall)
//   busy/done/stall        : status; done is high during the FIX cycle
//   hi/lo                  : HI/LO registers
module muldiv_seq #(
  parameter  int WIDTH = 32,
  localparam int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancelE,
  input  logic             hiweE,
  input  logic             loweE,
  input  logic [WIDTH-1:0] wdataE,
  input  logic             hlreadD,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2} state_e;

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_e           state_q;
  logic             busy_q, done_q;
  logic             isdiv_q, neg_q, rneg_q, div0_q;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  // acc_q: partial product high half / partial remainder
  // qr_q : multiplier being shifted out / dividend shifting into quotient
  // b_q  : multiplicand magnitude / divisor magnitude
  logic [WIDTH-1:0] acc_q, qr_q, b_q;
  logic [WIDTH-1:0] acc_d, qr_d;

  // operand magnitudes (opE[0]=0 selects signed)
  logic             sa, sb;
  logic [WIDTH-1:0] absa, absb;
  assign sa   = ~opE[0] & srcaE[WIDTH-1];
  assign sb   = ~opE[0] & srcbE[WIDTH-1];
  assign absa = sa ? -srcaE : srcaE;
  assign absb = sb ? -srcbE : srcbE;

  logic [WIDTH:0]       msum, dshift, dtrial;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  always_comb begin
    msum   = {1'b0, acc_q} + (qr_q[0] ? {1'b0, b_q} : '0);
    dshift = {acc_q, qr_q[WIDTH-1]};
    // dtrial[WIDTH] is the borrow: set when the divisor does not fit
    dtrial = dshift - {1'b0, b_q};
    if (isdiv_q) begin
      acc_d = dtrial[WIDTH] ? dshift[WIDTH-1:0] : dtrial[WIDTH-1:0];
      qr_d  = {qr_q[WIDTH-2:0], ~dtrial[WIDTH]};
    end else begin
      acc_d = msum[WIDTH:1];
      qr_d  = {msum[0], qr_q[WIDTH-1:1]};
    end
    prod_fix = neg_q  ? -{acc_q, qr_q} : {acc_q, qr_q};
    quo_fix  = neg_q  ? -qr_q  : qr_q;
    // With a zero divisor the remainder ends as |a|. Restoring the
    // dividend's sign therefore returns srcaE unchanged. MIN/-1 yields
    // quotient 2^(W-1), which is already the most-negative pattern.
    rem_fix  = rneg_q ? -acc_q : acc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      isdiv_q <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      qr_q    <= '0;
      b_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hiweE) hi_q <= wdataE;
          if (loweE) lo_q <= wdataE;
          if (startE && !cancelE) begin
            state_q <= ITER;
            busy_q  <= 1'b1;
            isdiv_q <= opE[1];
            neg_q   <= sa ^ sb;
            rneg_q  <= sa;
            div0_q  <= (srcbE == '0);
            cnt_q   <= '0;
            acc_q   <= '0;
            qr_q    <= absa;
            b_q     <= absb;
          end
        end
        ITER: begin
          if (cancelE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            qr_q  <= qr_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_q <= FIX;
              done_q  <= 1'b1;
            end
          end
        end
        FIX: begin
          // commit point: cancel no longer applies
          if (isdiv_q) begin
            hi_q <= rem_fix;
            lo_q <= div0_q ? '1 : quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy_q & (startE | hiweE | loweE | hlreadD);

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (WIDTH=32): directed test-plan steps
// plus randomized ops compared against an arithmetic reference model.
module tb_muldiv_seq;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          startE, cancelE, hiweE, loweE, hlreadD;
  logic [1:0]    opE;
  logic [W-1:0]  srcaE, srcbE, wdataE;
  logic          busy, done, stall;
  logic [W-1:0]  hi, lo;

  int checks   = 0;
  int failures = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .startE(startE), .opE(opE),
    .srcaE(srcaE), .srcbE(srcbE), .cancelE(cancelE),
    .hiweE(hiweE), .loweE(loweE), .wdataE(wdataE), .hlreadD(hlreadD),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // reference model: MIPS-style mult/div semantics in plain arithmetic
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, b,
                                output logic [W-1:0] h, l);
    longint      sp;
    logic [63:0] up;
    int          ia, ib;
    ia = a; ib = b;
    h = '0; l = '0;
    case (op)
      2'd0: begin sp = longint'(ia) * longint'(ib); {h, l} = sp; end
      2'd1: begin up = {32'b0, a} * {32'b0, b}; {h, l} = up; end
      2'd2: begin
        if (b == 0)                                 begin l = '1; h = a; end
        else if (a == 32'h8000_0000 && b == '1)     begin l = a;  h = '0; end
        else                                        begin l = ia / ib; h = ia % ib; end
      end
      default: begin
        if (b == 0) begin l = '1; h = a; end
        else        begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // full op with per-cycle busy/done checks and final HI/LO check
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, b, input string tag);
    logic [W-1:0] eh, el;
    model(op, a, b, eh, el);
    startE = 1'b1; opE = op; srcaE = a; srcbE = b;
    tick();                               // edge 0
    startE = 1'b0;
    for (int k = 0; k <= W; k++) begin
      chk({tag, "/busy_done"}, {62'b0, busy, done}, {62'b0, 1'b1, 1'(k == W)});
      if (k < W) tick();
    end
    tick();                               // edge W+1
    chk({tag, "/idle"}, {62'b0, busy, done}, 64'd0);
    chk({tag, "/hilo"}, {hi, lo}, {eh, el});
  endtask

  task automatic write_hilo(input logic [W-1:0] h, l);
    hiweE = 1'b1; wdataE = h; tick(); hiweE = 1'b0;
    loweE = 1'b1; wdataE = l; tick(); loweE = 1'b0;
  endtask

  initial begin
    logic [W-1:0] eh, el, ra, rb;
    logic [1:0]   rop;
    reset = 1'b0; startE = 0; cancelE = 0; hiweE = 0; loweE = 0; hlreadD = 0;
    opE = '0; srcaE = '0; srcbE = '0; wdataE = '0;
    #3;
    chk("reset/status", {61'b0, busy, done, stall}, 64'd0);
    chk("reset/hilo", {hi, lo}, 64'd0);
    @(negedge clk); reset = 1'b1;
    tick();

    // directed test plan
    run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, "mult_-3x7");
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_-1x-1");
    run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, "div_-7/2");
    run_op(2'd3, 32'h0000_0064, 32'h0000_0000, "divu_by0");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'd3, 32'h0000_0007, 32'h0000_0003, "divu_7/3");
    run_op(2'd2, 32'h8000_0000, 32'h0000_0000, "div_min_by0");
    run_op(2'd2, 32'h0000_0007, 32'hFFFF_FFFE, "div_7/-2");

    // mthi/mtlo in idle, then write coinciding with start, then write while busy
    write_hilo(32'h1234_5678, 32'h9ABC_DEF0);
    chk("mthilo/idle", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    hiweE = 1'b1; wdataE = 32'hAAAA_5555;
    startE = 1'b1; opE = 2'd0; srcaE = 32'd3; srcbE = 32'd5;
    tick();
    hiweE = 1'b0; startE = 1'b0;
    chk("mthi_with_start", {hi, busy}, {32'hAAAA_5555, 1'b1});
    tick(); tick();
    loweE = 1'b1; wdataE = 32'h0BAD_0BAD; #1;
    chk("mtlo_busy/stall", {63'b0, stall}, 64'd1);
    tick(); loweE = 1'b0;
    chk("mtlo_busy/ignored", {32'b0, lo}, 64'h9ABC_DEF0);
    for (int k = 4; k <= W + 1; k++) tick();
    chk("start_overwrite/hilo", {hi, lo}, 64'h0000_0000_0000_000F);

    // hazard: second start + hlreadD while busy is stalled and dropped
    write_hilo(32'h1234_5678, 32'h9ABC_DEF0);
    model(2'd0, 32'h0001_0003, 32'hFFFF_0005, eh, el);
    startE = 1'b1; opE = 2'd0; srcaE = 32'h0001_0003; srcbE = 32'hFFFF_0005;
    tick(); startE = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    startE = 1'b1; opE = 2'd3; srcaE = 32'd100; srcbE = 32'd9; hlreadD = 1'b1;
    for (int k = 5; k <= W; k++) begin
      tick();
      chk("hazard/stall", {62'b0, stall, busy}, 64'd3);
    end
    chk("hazard/done", {63'b0, done}, 64'd1);
    startE = 1'b0; hlreadD = 1'b0;
    tick();
    chk("hazard/hilo_first_op", {hi, lo}, {eh, el});
    tick();
    chk("hazard/second_ignored", {62'b0, busy, done}, 64'd0);

    // cancel at cycle 10
    write_hilo(32'h1234_5678, 32'h9ABC_DEF0);
    startE = 1'b1; opE = 2'd2; srcaE = 32'd1000; srcbE = 32'd7;
    tick(); startE = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    cancelE = 1'b1;
    tick(); cancelE = 1'b0;
    chk("cancel/busy", {62'b0, busy, done}, 64'd0);
    for (int k = 0; k < W + 2; k++) begin
      tick();
      if (done) chk("cancel/no_done", {63'b0, done}, 64'd0);
    end
    chk("cancel/hilo_kept", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    hlreadD = 1'b1; #1;
    chk("idle/no_stall", {63'b0, stall}, 64'd0);
    hlreadD = 1'b0;

    // randomized ops with corner-biased operands
    for (int n = 0; n < 16; n++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: ra = '0;  1: ra = '1;  2: ra = 32'h8000_0000;
        3: ra = 32'($urandom_range(0, 50));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = '0;  1: rb = '1;  2: rb = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 50));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", n, rop));
    end

    // asynchronous reset mid-div
    run_op(2'd0, 32'd3, 32'd5, "pre_reset");
    startE = 1'b1; opE = 2'd2; srcaE = 32'd100; srcbE = 32'd7; hlreadD = 1'b1;
    tick(); startE = 1'b0;
    for (int k = 1; k <= 17; k++) tick();
    #2 reset = 1'b0;
    #1;
    chk("async_reset/status", {61'b0, busy, done, stall}, 64'd0);
    chk("async_reset/hilo", {hi, lo}, 64'd0);
    hlreadD = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    tick();
    chk("post_reset/idle", {62'b0, busy, done}, 64'd0);
    run_op(2'd0, 32'd3, 32'd5, "post_reset_mult");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Sequential multiply/divide unit with private HI/LO registers. Replaces the single-cycle combinational mult/div path in the execute stage.
- Width is parametrised. Supports signed and unsigned mult and div, plus mthi/mtlo writes.
- A multi-cycle iteration drives a stall request back to the hazard unit.
- Sits in E: operands come after forwarding muxes; HI/LO outputs feed the writeback result mux.

Parameters:
- WIDTH, 32, operand and HI/LO width (even, >=4).
- CNTW, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- startE  in  1  request to begin the op selected by opE with srcaE/srcbE.
- opE  in  2  00 mult, 01 multu, 10 div, 11 divu.
- srcaE  in  WIDTH  multiplicand / dividend.
- srcbE  in  WIDTH  multiplier / divisor.
- cancelE  in  1  flush: abort any op in flight.
- hiweE  in  1  mthi write strobe.
- loweE  in  1  mtlo write strobe.
- wdataE  in  WIDTH  mthi/mtlo data.
- hlreadD  in  1  an mfhi/mflo is in decode.
- busy  out  1  iteration in progress.
- done  out  1  one-cycle pulse on the edge HI/LO take a result.
- stall  out  1  stall request to the hazard unit.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, async): state=IDLE; hi=0, lo=0, busy=0, done=0, stall=0; counter and datapath regs cleared. Reset mid-op aborts the op and leaves HI/LO=0.
- States are IDLE, ITER and FIX.
- IDLE:
  - startE=1 and cancelE=0: latch operands as absolute values when signed and the operand MSB=1; record result signs; count=0; go to ITER.
  - cancelE=1 in the same cycle: start is ignored.
- ITER: one radix-2 step per cycle.
  - mult: shift-add.
  - div: restoring shift-subtract.
  - count increments each cycle; after WIDTH steps go to FIX.
  - cancelE=1: go to IDLE next edge; HI/LO unchanged; no done pulse.
- FIX: apply sign correction and write HI/LO. Pulse done=1 for that one cycle, then go to IDLE.
- Latency:
  - Start sampled at edge 0.
  - HI/LO updated at edge WIDTH+1.
  - busy=1 from edge 0 through edge WIDTH+1, i.e. WIDTH+1 cycles (ITER + FIX).
  - Back-to-back start is accepted the cycle after done.
- Mult result: {hi,lo} = full 2*WIDTH-bit product. For signed, negate the product when the operand signs differ.
- Div result:
  - lo = quotient, truncated toward zero.
  - hi = remainder, with the dividend's sign.
- Divide by zero: lo = all ones, hi = srcaE as given (unsigned and signed alike). Still takes full latency.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- mthi/mtlo:
  - In IDLE, hiweE/loweE write wdataE at the next edge.
  - If startE is also set, the write applies now and the op result overwrites HI/LO later.
  - While busy, writes are ignored.
- stall = busy & (startE | hiweE | loweE | hlreadD). This is combinational, so a new op, HI/LO write or HI/LO read is held until the unit is free.
- startE while busy: ignored (no re-latch); stall=1.
- hi/lo are register outputs with no bypass; a read in the cycle of done sees the old value. The hazard unit covers this because stall is high that cycle.

Test Plan (WIDTH=32):
1. mult, srca=FFFFFFFD (-3), srcb=00000007: done at edge 33; hi=FFFFFFFF, lo=FFFFFFEB; busy high for 33 cycles.
2. multu FFFFFFFF*FFFFFFFF: hi=FFFFFFFE, lo=00000001. Then mult of the same operands (-1*-1): hi=00000000, lo=00000001.
3. div FFFFFFF9/00000002 (-7/2): lo=FFFFFFFD, hi=FFFFFFFF. Then divu 00000064/00000000: lo=FFFFFFFF, hi=00000064.
4. div 80000000/FFFFFFFF: lo=80000000, hi=00000000, no X. divu 00000007/00000003: lo=2, hi=1.
5. Hazards:
   - Start mult, then assert hlreadD and a second startE at cycle 5: stall=1 until done; the second start is ignored.
   - cancelE at cycle 10: busy drops next edge, no done, HI/LO keep prior values (preload via mthi=12345678, mtlo=9ABCDEF0).
6. Reset:
   - Drive reset=0 asynchronously at cycle 17 of a div: hi=lo=0 and busy=0 immediately, without waiting for a clock edge.
   - After release, a fresh mult 3*5 gives lo=0000000F, hi=0.
